decode_issue: RTL

Registered, parametrised decode-and-issue stage between the instruction queue and the Tomasulo back end (ROB, reservation station, load/store buffer). It holds one decoded RV32I instruction in an output register and fires it to the ROB plus exactly one of RS/LSB. A transfer happens only when every required target has room. It also drives the register-file rename write, honours ROB flush, and counts stall cycles.

---
 rtl/decode_issue_pkg.sv | 85 ++++++++
 rtl/decode_issue_inst_decode.sv | 143 ++++++++++++++
 rtl/decode_issue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/decode_issue_pkg.sv
// Shared RV32I constants, op-id encodings and route type
// for the decode/issue stage.
package decode_issue_pkg;

  localparam int OpIdBus = 6;
  typedef logic [OpIdBus-1:0] op_id_t;

  typedef enum logic {
    RT_RS,
    RT_LSB
  } route_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam op_id_t OP_NOP   = 6'd0;
  localparam op_id_t OP_LUI   = 6'd1;
  localparam op_id_t OP_AUIPC = 6'd2;
  localparam op_id_t OP_JAL   = 6'd3;
  localparam op_id_t OP_JALR  = 6'd4;
  localparam op_id_t OP_BEQ   = 6'd5;
  localparam op_id_t OP_BNE   = 6'd6;
  localparam op_id_t OP_BLT   = 6'd7;
  localparam op_id_t OP_BGE   = 6'd8;
  localparam op_id_t OP_BLTU  = 6'd9;
  localparam op_id_t OP_BGEU  = 6'd10;
  localparam op_id_t OP_LB    = 6'd11;
  localparam op_id_t OP_LH    = 6'd12;
  localparam op_id_t OP_LW    = 6'd13;
  localparam op_id_t OP_LBU   = 6'd14;
  localparam op_id_t OP_LHU   = 6'd15;
  localparam op_id_t OP_SB    = 6'd16;
  localparam op_id_t OP_SH    = 6'd17;
  localparam op_id_t OP_SW    = 6'd18;
  localparam op_id_t OP_ADDI  = 6'd19;
  localparam op_id_t OP_SLTI  = 6'd20;
  localparam op_id_t OP_SLTIU = 6'd21;
  localparam op_id_t OP_XORI  = 6'd22;
  localparam op_id_t OP_ORI   = 6'd23;
  localparam op_id_t OP_ANDI  = 6'd24;
  localparam op_id_t OP_SLLI  = 6'd25;
  localparam op_id_t OP_SRLI  = 6'd26;
  localparam op_id_t OP_SRAI  = 6'd27;
  localparam op_id_t OP_ADD   = 6'd28;
  localparam op_id_t OP_SUB   = 6'd29;
  localparam op_id_t OP_SLL   = 6'd30;
  localparam op_id_t OP_SLT   = 6'd31;
  localparam op_id_t OP_SLTU  = 6'd32;
  localparam op_id_t OP_XOR   = 6'd33;
  localparam op_id_t OP_SRL   = 6'd34;
  localparam op_id_t OP_SRA   = 6'd35;
  localparam op_id_t OP_OR    = 6'd36;
  localparam op_id_t OP_AND   = 6'd37;

endpackage

// File: rtl/decode_issue_inst_decode.sv
// Combinational RV32I decoder: op id, immediate, register
// indices, rd-write flag and back-end route.
module inst_decode
  import decode_issue_pkg::*;
(
  input  logic [31:0] i_inst,
  output op_id_t      o_op_id,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_writes_rd,
  output route_t      o_route
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_alt;
  logic        w_ok;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b;
  logic [31:0] w_imm_u, w_imm_j, w_imm_sh;
  op_id_t      w_op;
  logic [31:0] w_imm;
  logic        w_use_rd, w_use_rs1, w_use_rs2;
  route_t      w_route;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_alt = (i_inst[31:25] & F7_ALT) != F7_BASE;

  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25],
                     i_inst[11:7]};
  assign w_imm_b  = {{20{i_inst[31]}}, i_inst[7],
                     i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_j  = {{12{i_inst[31]}}, i_inst[19:12],
                     i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_inst[24:20]};

  always_comb begin
    w_op      = OP_NOP;
    w_imm     = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_route   = RT_RS;
    unique case (1'b1)
      w_opc == OPC_LUI: begin
        w_op = OP_LUI; w_imm = w_imm_u; w_use_rd = 1'b1;
      end
      w_opc == OPC_AUIPC: begin
        w_op = OP_AUIPC; w_imm = w_imm_u; w_use_rd = 1'b1;
      end
      w_opc == OPC_JAL: begin
        w_op = OP_JAL; w_imm = w_imm_j; w_use_rd = 1'b1;
      end
      w_opc == OPC_JALR: begin
        w_op      = (w_f3 == 3'd0) ? OP_JALR : OP_NOP;
        w_imm     = w_imm_i;
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      w_opc == OPC_BRANCH: begin
        unique case (w_f3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_op = OP_NOP;
        endcase
        w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      w_opc == OPC_LOAD: begin
        unique case (w_f3)
          F3_B:    w_op = OP_LB;
          F3_H:    w_op = OP_LH;
          F3_W:    w_op = OP_LW;
          F3_BU:   w_op = OP_LBU;
          F3_HU:   w_op = OP_LHU;
          default: w_op = OP_NOP;
        endcase
        w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        w_route = RT_LSB;
      end
      w_opc == OPC_STORE: begin
        unique case (w_f3)
          F3_B:    w_op = OP_SB;
          F3_H:    w_op = OP_SH;
          F3_W:    w_op = OP_SW;
          default: w_op = OP_NOP;
        endcase
        w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_route = RT_LSB;
      end
      w_opc == OPC_OPIMM: begin
        w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        unique case (w_f3)
          F3_ADD:  w_op = OP_ADDI;
          F3_SLT:  w_op = OP_SLTI;
          F3_SLTU: w_op = OP_SLTIU;
          F3_XOR:  w_op = OP_XORI;
          F3_OR:   w_op = OP_ORI;
          F3_AND:  w_op = OP_ANDI;
          F3_SLL: begin
            w_op = OP_SLLI; w_imm = w_imm_sh;
          end
          default: begin
            w_op  = w_alt ? OP_SRAI : OP_SRLI;
            w_imm = w_imm_sh;
          end
        endcase
      end
      w_opc == OPC_OP: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        unique case (w_f3)
          F3_ADD:  w_op = w_alt ? OP_SUB : OP_ADD;
          F3_SLL:  w_op = OP_SLL;
          F3_SLT:  w_op = OP_SLT;
          F3_SLTU: w_op = OP_SLTU;
          F3_XOR:  w_op = OP_XOR;
          F3_SR:   w_op = w_alt ? OP_SRA : OP_SRL;
          F3_OR:   w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      default: w_op = OP_NOP;
    endcase
  end

  // Anything that fails to decode becomes an inert NOP on the RS path.
  assign w_ok        = w_op != OP_NOP;
  assign o_op_id     = w_op;
  assign o_imm       = w_ok ? w_imm : '0;
  assign o_writes_rd = w_ok && w_use_rd;
  assign o_rd        = o_writes_rd ? i_inst[11:7] : 5'd0;
  assign o_rs1       = (w_ok && w_use_rs1) ? i_inst[19:15] : 5'd0;
  assign o_rs2       = (w_ok && w_use_rs2) ? i_inst[24:20] : 5'd0;
  assign o_route     = w_ok ? w_route : RT_RS;

endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: one-entry holding register that fires
// into the ROB plus RS or LSB, with rename strobe and stall count.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int ROB_TAG_W = 4,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [XLEN-1:0]      iq_pc,
  output logic                 iq_ready,
  input  logic                 rob_full,
  input  logic [ROB_TAG_W-1:0] rob_tail_tag,
  input  logic                 rob_flush,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 rob_en,
  output logic                 rs_en,
  output logic                 lsb_en,
  output logic [OpIdBus-1:0]   d_op_id,
  output logic [XLEN-1:0]      d_pc,
  output logic [XLEN-1:0]      d_imm,
  output logic [4:0]           d_rd,
  output logic [4:0]           d_rs1,
  output logic [4:0]           d_rs2,
  output logic [ROB_TAG_W-1:0] d_tag,
  output logic                 rf_rename_en,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  state_t                 r_state, w_state_nx;
  op_id_t                 r_op_id;
  logic [XLEN-1:0]        r_pc, r_imm;
  logic [4:0]             r_rd, r_rs1, r_rs2;
  logic                   r_wr;
  route_t                 r_route;
  logic [ROB_TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]       r_stall;

  op_id_t                 w_op_id;
  logic [31:0]            w_imm;
  logic [4:0]             w_rd, w_rs1, w_rs2;
  logic                   w_wr;
  route_t                 w_route;
  logic                   w_room, w_fire, w_capture;

  inst_decode u_dec (
    .i_inst      (iq_inst),
    .o_op_id     (w_op_id),
    .o_imm       (w_imm),
    .o_rd        (w_rd),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_writes_rd (w_wr),
    .o_route     (w_route)
  );

  always_comb begin
    w_room    = (r_route == RT_LSB) ? !lsb_full : !rs_full;
    w_fire    = (r_state == ST_FULL) && !rob_flush
                && !rob_full && w_room;
    iq_ready  = !rob_flush && (r_state == ST_EMPTY || w_fire);
    w_capture = iq_valid && iq_ready;
    rob_en    = w_fire;
    rs_en     = w_fire && (r_route == RT_RS);
    lsb_en    = w_fire && (r_route == RT_LSB);
    rf_rename_en = w_fire && r_wr && (r_rd != 5'd0);
    d_tag     = w_fire ? rob_tail_tag : r_tag;
    w_state_nx = r_state;
    if (rob_flush)      w_state_nx = ST_EMPTY;
    else if (w_capture) w_state_nx = ST_FULL;
    else if (w_fire)    w_state_nx = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_id <= OP_NOP;
      r_pc    <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_wr    <= 1'b0;
      r_route <= RT_RS;
      r_tag   <= '0;
      r_stall <= '0;
    end else begin
      if (w_capture) begin
        r_op_id <= w_op_id;
        r_pc    <= iq_pc;
        r_imm   <= XLEN'($signed(w_imm));
        r_rd    <= w_rd;
        r_rs1   <= w_rs1;
        r_rs2   <= w_rs2;
        r_wr    <= w_wr;
        r_route <= w_route;
      end
      if (w_fire) r_tag <= rob_tail_tag;
      if (r_state == ST_FULL && !w_fire && r_stall != '1)
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign d_op_id   = r_op_id;
  assign d_pc      = r_pc;
  assign d_imm     = r_imm;
  assign d_rd      = r_rd;
  assign d_rs1     = r_rs1;
  assign d_rs2     = r_rs2;
  assign stall_cnt = r_stall;

endmodule
